// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: in-order writeback FIFO draining to the register file write port with newest-value bypass
module regfile_writeback_queue #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ld_valid,
  input  logic [ADDR_W-1:0]       ld_rd,
  input  logic [DATA_W-1:0]       ld_data,
  output logic                    ld_ready,
  input  logic                    alu_valid,
  input  logic [ADDR_W-1:0]       alu_rd,
  input  logic [DATA_W-1:0]       alu_data,
  output logic                    alu_ready,
  input  logic                    wb_stall,
  output logic                    RegWrite,
  output logic [ADDR_W-1:0]       RD,
  output logic [DATA_W-1:0]       WriteData,
  input  logic [ADDR_W-1:0]       RS1,
  input  logic [ADDR_W-1:0]       RS2,
  output logic                    fwd1_hit,
  output logic [DATA_W-1:0]       fwd1_data,
  output logic                    fwd2_hit,
  output logic [DATA_W-1:0]       fwd2_data,
  output logic [$clog2(DEPTH):0]  pending
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] r_rd [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [PW:0]       r_cnt;
  logic              w_full, w_push, w_pop;
  logic [ADDR_W-1:0] w_rd;
  logic [DATA_W-1:0] w_data;
  logic [PW-1:0]     w_idx;
  assign w_full    = r_cnt == (PW+1)'(DEPTH);
  assign ld_ready  = !w_full;
  assign alu_ready = !w_full && !ld_valid;
  assign w_rd      = ld_valid ? ld_rd : alu_rd;
  assign w_data    = ld_valid ? ld_data : alu_data;
  assign w_push    = ((ld_valid && ld_ready) || (alu_valid && alu_ready)) && w_rd != '0;
  assign w_pop     = r_cnt != '0 && !wb_stall;
  assign pending   = r_cnt;
  // Store accepted results at the tail; x0 writes complete the handshake but are never stored
  always_ff @(posedge clk)
    if (w_push) begin
      r_rd[r_wp]   <= w_rd;
      r_data[r_wp] <= w_data;
    end
  // Pointer/count bookkeeping and the registered register-file write stage
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_wp      <= '0;
      r_rp      <= '0;
      r_cnt     <= '0;
      RegWrite  <= 1'b0;
      RD        <= '0;
      WriteData <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt    <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
      RegWrite <= w_pop;
      if (w_pop) begin
        RD        <= r_rd[r_rp];
        WriteData <= r_data[r_rp];
      end
    end
  // Bypass: scan oldest (output stage) to newest so the youngest match overrides
  always_comb begin
    fwd1_hit  = RegWrite && RD == RS1;
    fwd1_data = fwd1_hit ? WriteData : '0;
    fwd2_hit  = RegWrite && RD == RS2;
    fwd2_data = fwd2_hit ? WriteData : '0;
    w_idx     = r_rp;
    for (int k = 0; k < DEPTH; k++) begin
      if ((PW+1)'(k) < r_cnt && r_rd[w_idx] == RS1) begin
        fwd1_hit  = 1'b1;
        fwd1_data = r_data[w_idx];
      end
      if ((PW+1)'(k) < r_cnt && r_rd[w_idx] == RS2) begin
        fwd2_hit  = 1'b1;
        fwd2_data = r_data[w_idx];
      end
      w_idx = w_idx + 1'b1;
    end
    if (RS1 == '0) begin
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
    end
    if (RS2 == '0) begin
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
    end
  end
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb_regfile_writeback_queue: randomized and directed check of the writeback queue against a queue-based model
module tb_regfile_writeback_queue;
  localparam int DW = 64, AW = 5, D = 4, PW = $clog2(D) + 1;
  logic          clk = 1'b0, reset = 1'b0;
  logic          ld_valid = 1'b0, alu_valid = 1'b0, wb_stall = 1'b0;
  logic [AW-1:0] ld_rd = '0, alu_rd = '0, RS1 = '0, RS2 = '0;
  logic [DW-1:0] ld_data = '0, alu_data = '0;
  logic          ld_ready, alu_ready, RegWrite, fwd1_hit, fwd2_hit;
  logic [AW-1:0] RD;
  logic [DW-1:0] WriteData, fwd1_data, fwd2_data;
  logic [PW-1:0] pending;
  int            errs = 0, checks = 0;
  typedef struct packed {logic [AW-1:0] rd; logic [DW-1:0] data;} ent_t;
  ent_t          q[$];
  logic          m_we = 1'b0;
  logic [AW-1:0] m_rd = '0;
  logic [DW-1:0] m_wd = '0;
  bit            acc;

  regfile_writeback_queue #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .wb_stall(wb_stall), .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData),
    .RS1(RS1), .RS2(RS2), .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
    .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Youngest pending write to rs, searching queue newest-first, then the output stage
  function automatic logic [DW:0] lookup(input logic [AW-1:0] rs);
    if (rs == '0) return '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].rd == rs) return {1'b1, q[i].data};
    if (m_we && m_rd == rs) return {1'b1, m_wd};
    return '0;
  endfunction

  task automatic check_regs();
    chk("RegWrite", RegWrite, m_we);
    chk("RD", RD, m_rd);
    chk("WriteData", WriteData, m_wd);
    chk("pending", pending, q.size());
  endtask

  // One cycle: check comb outputs against the model, clock, advance model, check registered outputs
  task automatic step(output bit accepted);
    logic [DW:0] f1, f2;
    bit lr, ar;
    ent_t e;
    #1;
    lr = q.size() < D;
    ar = lr && !ld_valid;
    chk("ld_ready", ld_ready, lr);
    chk("alu_ready", alu_ready, ar);
    f1 = lookup(RS1);
    f2 = lookup(RS2);
    chk("fwd1_hit", fwd1_hit, f1[DW]);
    chk("fwd1_data", fwd1_data, f1[DW-1:0]);
    chk("fwd2_hit", fwd2_hit, f2[DW]);
    chk("fwd2_data", fwd2_data, f2[DW-1:0]);
    accepted = (ld_valid && lr) || (alu_valid && ar);
    e.rd   = ld_valid ? ld_rd : alu_rd;
    e.data = ld_valid ? ld_data : alu_data;
    @(posedge clk);
    if (q.size() > 0 && !wb_stall) begin
      m_we = 1'b1;
      m_rd = q[0].rd;
      m_wd = q[0].data;
      void'(q.pop_front());
    end else m_we = 1'b0;
    if (accepted && e.rd != '0) q.push_back(e);
    #1;
    check_regs();
  endtask

  task automatic idle(input int n);
    ld_valid = 1'b0;
    alu_valid = 1'b0;
    for (int i = 0; i < n; i++) step(acc);
  endtask

  initial begin
    ld_valid = 1'b1; alu_valid = 1'b1; ld_rd = 5'd9; alu_rd = 5'd9; RS1 = 5'd9; RS2 = 5'd9;
    repeat (2) @(posedge clk);
    #2;
    chk("rst ld_ready", ld_ready, 1'b1);
    chk("rst alu_ready", alu_ready, 1'b0);
    chk("rst fwd1_hit", fwd1_hit, 1'b0);
    check_regs();
    @(posedge clk); #1;
    reset = 1'b1;
    ld_valid = 1'b0; alu_valid = 1'b0; RS1 = '0; RS2 = '0;
    // single load latency
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 64'hAA; RS1 = 5'd5;
    step(acc);
    idle(3);
    // load priority over ALU
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 64'h33; alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'h44;
    step(acc);
    ld_valid = 1'b0;
    step(acc);
    idle(3);
    // stalled fill past capacity, then in-order drain across wrap
    wb_stall = 1'b1; RS1 = 5'd3; RS2 = 5'd4;
    for (int k = 1, n = 0; k <= 5 && n < 12; n++) begin
      ld_valid = 1'b1; ld_rd = AW'(k); ld_data = 64'h100 + k;
      step(acc);
      if (acc) k++;
      if (n == 8) wb_stall = 1'b0;
    end
    wb_stall = 1'b0;
    idle(6);
    // same-register bypass while stalled
    wb_stall = 1'b1; RS1 = 5'd7; RS2 = '0;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 64'h11; step(acc);
    ld_data = 64'h22; step(acc);
    idle(2);
    wb_stall = 1'b0;
    idle(3);
    // x0 result is dropped
    alu_valid = 1'b1; alu_rd = '0; alu_data = 64'hDEAD; step(acc);
    alu_valid = 1'b0;
    idle(2);
    // async reset mid-drain
    wb_stall = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      ld_valid = 1'b1; ld_rd = AW'(k + 10); ld_data = 64'h200 + k; step(acc);
    end
    wb_stall = 1'b0;
    idle(1);
    #2 reset = 1'b0;
    #1;
    q.delete(); m_we = 1'b0; m_rd = '0; m_wd = '0;
    check_regs();
    @(posedge clk); #1;
    check_regs();
    reset = 1'b1;
    idle(4);
    // random traffic with frequent register collisions
    for (int n = 0; n < 400; n++) begin
      ld_valid  = ($urandom_range(0, 99) < 40);
      alu_valid = ($urandom_range(0, 99) < 50);
      ld_rd     = AW'($urandom_range(0, 7));
      alu_rd    = AW'($urandom_range(0, 7));
      ld_data   = {$urandom, $urandom};
      alu_data  = {$urandom, $urandom};
      wb_stall  = ($urandom_range(0, 99) < 35);
      RS1       = AW'($urandom_range(0, 7));
      RS2       = AW'($urandom_range(0, 7));
      step(acc);
    end
    wb_stall = 1'b0;
    idle(6);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/regfile_writeback_queue.md
Name: regfile_writeback_queue

Overview:
- Write-side companion to the 32x64 register file.
- Accepts completed results from the ALU and load paths using valid/ready handshakes.
- Buffers results in a small in-order FIFO and drains one per cycle onto the register file's RegWrite/RD/WriteData write port.
- Provides newest-value bypass for two read addresses, so readers see writes that are still pending in the queue.

Parameters:
- DATA_W, 64, result/register data width
- ADDR_W, 5, register address width (32 registers)
- DEPTH, 4, FIFO entries; power of two, at least 2

Ports:
- clk  input  1  single clock; all state updates on posedge
- reset  input  1  asynchronous, active-low reset
- ld_valid  input  1  load result valid
- ld_rd  input  ADDR_W  load destination register
- ld_data  input  DATA_W  load result
- ld_ready  output  1  queue can accept the load result this cycle
- alu_valid  input  1  ALU result valid
- alu_rd  input  ADDR_W  ALU destination register
- alu_data  input  DATA_W  ALU result
- alu_ready  output  1  queue can accept the ALU result this cycle
- wb_stall  input  1  hold drain; register file port unavailable
- RegWrite  output  1  register file write enable (registered)
- RD  output  ADDR_W  register file write address (registered)
- WriteData  output  DATA_W  register file write data (registered)
- RS1  input  ADDR_W  bypass lookup address 1
- RS2  input  ADDR_W  bypass lookup address 2
- fwd1_hit  output  1  RS1 has a pending write
- fwd1_data  output  DATA_W  newest pending value for RS1
- fwd2_hit  output  1  RS2 has a pending write
- fwd2_data  output  DATA_W  newest pending value for RS2
- pending  output  clog2(DEPTH)+1  number of occupied FIFO entries

Behaviour:
- Reset (reset=0, async):
  - FIFO emptied; read/write pointers and count cleared; pending=0.
  - RegWrite=0, RD=0, WriteData=0.
  - Entries in flight are discarded, with no partial write.
  - Comb outputs during reset: ld_ready=1, alu_ready=0 if ld_valid else 1, fwd*_hit=0.
- Enqueue, at most one per cycle:
  - ld_ready = !full.
  - alu_ready = !full && !ld_valid. Load has strict priority.
  - Transfer occurs on valid&&ready at posedge.
- Writes to register 0: a transfer with rd==0 completes its handshake but is not stored (dropped).
- Full/pop timing: full means count==DEPTH. A same-cycle pop does NOT free a slot for that cycle's enqueue; ready depends only on registered count.
- Drain:
  - Each posedge with count>0 and wb_stall=0: head pops into RegWrite/RD/WriteData with RegWrite=1.
  - Otherwise RegWrite<=0; RD and WriteData hold their last values.
  - Exactly one write is presented per cycle; the write happens at the following posedge inside the register file.
- Latency: an entry accepted at edge N, with an empty queue and no stall, appears on RegWrite at edge N+1 and is written to the register file at edge N+2.
- Ordering: strict FIFO. Writes to the same register are committed in acceptance order.
- Simultaneous enqueue and pop: count unchanged; pointers both advance.
- Wrap-around: pointers mod DEPTH. count is tracked separately, so full and empty are unambiguous.
- Bypass (combinational):
  - Search the valid FIFO entries plus the output stage when RegWrite=1.
  - Priority runs newest to oldest: tail-1 ... head, then the output stage.
  - A hit returns the youngest match's data. RS==0 never hits.
  - Entries being accepted this cycle are not searched.
  - With no hit, fwd_data=0.
- wb_stall asserted mid-stream: the output stage drops RegWrite next edge; the FIFO holds; bypass remains valid for all held entries.

Test Plan:
- Reset release, then ld_valid=1, ld_rd=5, ld_data=0xAA -> ld_ready=1; next edge pending=1; following edge RegWrite=1, RD=5, WriteData=0xAA, pending=0.
- ld_valid and alu_valid both high (ld_rd=3, alu_rd=4) -> alu_ready=0. Load enqueued first; ALU accepted the next cycle. Writes appear as RD=3 then RD=4.
- wb_stall=1 with 5 loads to regs 1..5 -> pending reaches 4, then ld_ready=0. The 5th is held until stall drops. Drain is in order 1..5 with no loss across pointer wrap.
- Enqueue x7=0x11 then x7=0x22 while stalled; RS1=7 -> fwd1_hit=1, fwd1_data=0x22. RS2=0 -> fwd2_hit=0.
- Enqueue alu_rd=0 -> alu_ready=1, handshake completes, pending stays 0, RegWrite never asserts.
- Assert reset low mid-drain with 3 pending -> immediately pending=0, RegWrite=0, RD=0, WriteData=0. After release, no stale writes appear.
